// File: rtl/satd_pkg.sv
// Shared sizing constants for the SATD block loader and its row banks.
package satd_pkg;

    localparam int WIDTH      = 8;
    localparam int SAMPLES    = 8;
    localparam int ITERATIONS = 7;

    localparam int ROWS      = ITERATIONS + 1;
    localparam int ROW_BITS  = WIDTH * SAMPLES;
    localparam int BLK_BITS  = ROW_BITS * ROWS;
    localparam int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

endpackage

// File: rtl/satd_row_bank.sv
// One ping-pong bank: stores a full block of ORG and CUR rows, one row written per cycle.
module satd_row_bank
    import satd_pkg::*;
#(
    parameter int ROW_W  = ROW_BITS,
    parameter int N_ROWS = ROWS,
    parameter int IDX_W  = ROW_IDX_W
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IDX_W-1:0]          row_idx,
    input  logic [ROW_W-1:0]          org_row,
    input  logic [ROW_W-1:0]          cur_row,
    output logic [ROW_W*N_ROWS-1:0]   org_blk,
    output logic [ROW_W*N_ROWS-1:0]   cur_blk
);

    logic [ROW_W*N_ROWS-1:0] org_mem_q, org_mem_d;
    logic [ROW_W*N_ROWS-1:0] cur_mem_q, cur_mem_d;

    // Overwrite only the addressed row slice; all other rows hold their contents.
    always_comb begin
        org_mem_d = org_mem_q;
        cur_mem_d = cur_mem_q;
        if (we) begin
            org_mem_d[row_idx*ROW_W +: ROW_W] = org_row;
            cur_mem_d[row_idx*ROW_W +: ROW_W] = cur_row;
        end
    end

    // Bank storage is deliberately left unreset; the top's full flags say when it is meaningful.
    always_ff @(posedge clk) begin
        org_mem_q <= org_mem_d;
        cur_mem_q <= cur_mem_d;
    end

    assign org_blk = org_mem_q;
    assign cur_blk = cur_mem_q;

endmodule

// File: rtl/satd_block_loader.sv
// Row-stream to block front end for the SATD datapath, using two banks in ping-pong.
module satd_block_loader
    import satd_pkg::*;
#(
    parameter int WIDTH      = satd_pkg::WIDTH,
    parameter int SAMPLES    = satd_pkg::SAMPLES,
    parameter int ITERATIONS = satd_pkg::ITERATIONS
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [WIDTH*SAMPLES-1:0]                 in_org,
    input  logic [WIDTH*SAMPLES-1:0]                 in_cur,
    input  logic                                     in_last,
    output logic                                     out_valid,
    input  logic                                     out_ack,
    output logic [WIDTH*SAMPLES*(ITERATIONS+1)-1:0]  ORG_BLK,
    output logic [WIDTH*SAMPLES*(ITERATIONS+1)-1:0]  CUR_BLK,
    output logic                                     row_err
);

    localparam int N_ROWS = ITERATIONS + 1;
    localparam int R_BITS = WIDTH * SAMPLES;
    localparam int B_BITS = R_BITS * N_ROWS;
    localparam int IDX_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic             row_err_q, row_err_d;

    logic             accept;
    logic             last_row;
    logic             early_last;
    logic             complete;
    logic             ack;
    logic [1:0]       bank_we;
    logic [B_BITS-1:0] org_blk0, org_blk1, cur_blk0, cur_blk1;

    // Handshake decode: a row enters only when the write bank is free and reset is low.
    always_comb begin
        in_ready   = !rst && !full_q[wr_sel_q];
        accept     = in_valid && in_ready;
        last_row   = (wr_row_q == IDX_W'(ITERATIONS));
        early_last = accept && in_last && !last_row;
        complete   = accept && last_row;
        ack        = out_ack && full_q[rd_sel_q];
        bank_we    = 2'b00;
        bank_we[wr_sel_q] = accept && !early_last;
    end

    // Control next state: row counter, bank flags, pointers and framing error detection.
    always_comb begin
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_row_d  = wr_row_q;
        row_err_d = accept && (in_last != last_row);
        if (ack) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end
        if (early_last) begin
            wr_row_d = '0;
        end else if (complete) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
            wr_row_d         = '0;
        end else if (accept) begin
            wr_row_d = wr_row_q + IDX_W'(1);
        end
    end

    // Control registers with synchronous reset; any pending or partial block is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            wr_row_q  <= '0;
            row_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_row_q  <= wr_row_d;
            row_err_q <= row_err_d;
        end
    end

    satd_row_bank #(.ROW_W(R_BITS), .N_ROWS(N_ROWS), .IDX_W(IDX_W)) u_bank0 (
        .clk     (clk),
        .we      (bank_we[0]),
        .row_idx (wr_row_q),
        .org_row (in_org),
        .cur_row (in_cur),
        .org_blk (org_blk0),
        .cur_blk (cur_blk0)
    );

    satd_row_bank #(.ROW_W(R_BITS), .N_ROWS(N_ROWS), .IDX_W(IDX_W)) u_bank1 (
        .clk     (clk),
        .we      (bank_we[1]),
        .row_idx (wr_row_q),
        .org_row (in_org),
        .cur_row (in_cur),
        .org_blk (org_blk1),
        .cur_blk (cur_blk1)
    );

    // Present the read bank only while it holds a complete block, otherwise drive zeros.
    always_comb begin
        out_valid = full_q[rd_sel_q];
        ORG_BLK   = '0;
        CUR_BLK   = '0;
        if (out_valid) begin
            ORG_BLK = rd_sel_q ? org_blk1 : org_blk0;
            CUR_BLK = rd_sel_q ? cur_blk1 : cur_blk0;
        end
    end

    assign row_err = row_err_q;

endmodule

// File: tb/tb_satd_block_loader.sv
// Self-checking bench for satd_block_loader against a queue-based block model.
module tb_satd_block_loader;

    localparam int RB    = 64;
    localparam int BB    = 512;
    localparam int LASTR = 7;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [RB-1:0] in_org;
    logic [RB-1:0] in_cur;
    logic          in_last;
    logic          out_valid;
    logic          out_ack;
    logic [BB-1:0] ORG_BLK;
    logic [BB-1:0] CUR_BLK;
    logic          row_err;

    satd_block_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_org    (in_org),
        .in_cur    (in_cur),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .ORG_BLK   (ORG_BLK),
        .CUR_BLK   (CUR_BLK),
        .row_err   (row_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int dut_acks;

    logic [BB-1:0] pend_org[$];
    logic [BB-1:0] pend_cur[$];
    logic [BB-1:0] part_org;
    logic [BB-1:0] part_cur;
    int            part_cnt;
    logic          err_exp;

    logic [RB-1:0] rows_o[32];
    logic [RB-1:0] rows_c[32];

    function automatic logic [RB-1:0] pat(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [RB-1:0] rnd_row();
        logic [RB-1:0] r;
        r = {$urandom, $urandom};
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with what the model says should be visible now.
    task automatic checkOutput();
        logic          exp_ready;
        logic          exp_valid;
        logic [BB-1:0] exp_org;
        logic [BB-1:0] exp_cur;
        exp_ready = !rst && (pend_org.size() < 2);
        exp_valid = (pend_org.size() > 0);
        exp_org   = exp_valid ? pend_org[0] : '0;
        exp_cur   = exp_valid ? pend_cur[0] : '0;
        cmp("in_ready",  BB'(in_ready),  BB'(exp_ready));
        cmp("out_valid", BB'(out_valid), BB'(exp_valid));
        cmp("row_err",   BB'(row_err),   BB'(err_exp));
        cmp("ORG_BLK",   ORG_BLK,        exp_org);
        cmp("CUR_BLK",   CUR_BLK,        exp_cur);
        if (out_valid === 1'b1 && out_ack === 1'b1) dut_acks++;
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model across the edge.
    task automatic applyStimulus(input logic v, input logic [RB-1:0] org, input logic [RB-1:0] cur,
                                 input logic last, input logic ack, input logic r, output logic acc);
        logic exp_ready;
        in_valid = v;
        in_org   = org;
        in_cur   = cur;
        in_last  = last;
        out_ack  = ack;
        rst      = r;
        #1;
        checkOutput();
        exp_ready = !r && (pend_org.size() < 2);
        acc = v && exp_ready;
        if (r) begin
            pend_org.delete();
            pend_cur.delete();
            part_cnt = 0;
            err_exp  = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (ack && pend_org.size() > 0) begin
                pend_org.delete(0);
                pend_cur.delete(0);
            end
            if (acc) begin
                if (last && part_cnt < LASTR) begin
                    err_exp  = 1'b1;
                    part_cnt = 0;
                end else begin
                    part_org[part_cnt*RB +: RB] = org;
                    part_cur[part_cnt*RB +: RB] = cur;
                    if (part_cnt == LASTR) begin
                        pend_org.push_back(part_org);
                        pend_cur.push_back(part_cur);
                        err_exp  = !last;
                        part_cnt = 0;
                    end else begin
                        part_cnt++;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    // Hold a row on the bus until it is taken, within a fixed cycle budget.
    task automatic sendRow(input logic [RB-1:0] org, input logic [RB-1:0] cur,
                           input logic last, input logic ack);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            applyStimulus(1'b1, org, cur, last, ack, 1'b0, acc);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout observed=stalled expected=accepted");
        end
    endtask

    task automatic idle(input int n, input logic ack);
        logic acc;
        for (int t = 0; t < n; t++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, ack, 1'b0, acc);
        end
    endtask

    initial begin
        logic acc;
        int   acks_before;
        checks   = 0;
        errors   = 0;
        dut_acks = 0;
        part_cnt = 0;
        err_exp  = 1'b0;
        part_org = '0;
        part_cur = '0;
        in_valid = 1'b0;
        in_org   = '0;
        in_cur   = '0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] reset state");
        applyStimulus(1'b1, pat(8'h11), pat(8'h22), 1'b0, 1'b0, 1'b1, acc);
        idle(1, 1'b0);

        $display("[TB] single patterned block");
        for (int k = 0; k <= LASTR; k++) begin
            sendRow(pat(8'(k)), pat(8'(8'hFF - k)), k == LASTR, 1'b0);
        end
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        $display("[TB] 24 rows without ack");
        for (int k = 0; k < 24; k++) begin
            rows_o[k] = rnd_row();
            rows_c[k] = rnd_row();
        end
        for (int k = 0; k < 16; k++) begin
            sendRow(rows_o[k], rows_c[k], (k % 8) == LASTR, 1'b0);
        end
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1'b1, rows_o[16], rows_c[16], 1'b0, 1'b0, 1'b0, acc);
        end
        applyStimulus(1'b1, rows_o[16], rows_c[16], 1'b0, 1'b1, 1'b0, acc);
        for (int k = 16; k < 24; k++) begin
            sendRow(rows_o[k], rows_c[k], (k % 8) == LASTR, 1'b0);
        end
        idle(1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] 32 rows with ack held high");
        acks_before = dut_acks;
        for (int k = 0; k < 32; k++) begin
            sendRow(rnd_row(), rnd_row(), (k % 8) == LASTR, 1'b1);
        end
        idle(2, 1'b1);
        cmp("ack_count", BB'(dut_acks - acks_before), BB'(4));

        $display("[TB] early in_last");
        for (int k = 0; k < 4; k++) begin
            sendRow(rnd_row(), rnd_row(), k == 3, 1'b0);
        end
        idle(2, 1'b0);
        for (int k = 0; k <= LASTR; k++) begin
            sendRow(rnd_row(), rnd_row(), k == LASTR, 1'b0);
        end
        idle(1, 1'b0);
        idle(1, 1'b1);

        $display("[TB] missing in_last and stray ack");
        for (int k = 0; k <= LASTR; k++) begin
            sendRow(rnd_row(), rnd_row(), 1'b0, 1'b0);
        end
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b1);
        idle(1, 1'b0);

        $display("[TB] reset with a block pending");
        for (int k = 0; k <= LASTR; k++) begin
            sendRow(rnd_row(), rnd_row(), k == LASTR, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            sendRow(rnd_row(), rnd_row(), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        idle(1, 1'b0);
        for (int k = 0; k <= LASTR; k++) begin
            sendRow(rnd_row(), rnd_row(), k == LASTR, 1'b0);
        end
        idle(1, 1'b0);
        idle(1, 1'b1);

        $display("[TB] random traffic");
        for (int t = 0; t < 400; t++) begin
            logic v, a, l, r;
            v = ($urandom_range(3, 0) != 0);
            a = ($urandom_range(2, 0) == 0);
            l = (part_cnt == LASTR) ^ ($urandom_range(15, 0) == 0);
            r = ($urandom_range(63, 0) == 0);
            applyStimulus(v, rnd_row(), rnd_row(), l, a, r, acc);
        end
        idle(4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
